// File: rtl/lfsr_chk_pkg.sv
// Shared types and default sizing for the LFSR signature checker.
package lfsr_chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARM,
      WAIT,
      REPORT
   } state_t;

   localparam int NBITS_DEF   = 16;
   localparam int DATA_W_DEF  = 128;
   localparam int TIMEOUT_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/lfsr_sig_check.sv
// Seeds the LFSR, waits for a fresh ready edge, captures and compares the
// signature, then reports the result over a valid/ready handshake.
module lfsr_sig_check
   import lfsr_chk_pkg::*;
#(
   parameter int NBITS   = NBITS_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNTW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NBITS-1:0]  seed,
   input  logic [NBITS-1:0]  expected,
   output logic              lfsr_we,
   output logic [DATA_W-1:0] lfsr_data,
   input  logic [NBITS-1:0]  lfsr_q,
   input  logic              lfsr_rdy,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_pass,
   output logic              res_timeout,
   output logic [NBITS-1:0]  res_sig,
   output logic [CNTW-1:0]   pass_cnt,
   output logic [CNTW-1:0]   fail_cnt
);

   // One spare bit: leaving ARM on the last allowed cycle pushes the count past the limit.
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

   state_t state_q, state_d;
   logic [NBITS-1:0] seed_q, exp_q;
   logic [TW-1:0]    tcnt;
   logic accept, tclr, tinc, capture, cap_timeout, done;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      tclr        = 1'b0;
      tinc        = 1'b0;
      capture     = 1'b0;
      cap_timeout = 1'b0;
      done        = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            accept  = 1'b1;
            state_d = LOAD;
         end
         LOAD: begin
            tclr    = 1'b1;
            state_d = ARM;
         end
         ARM: begin
            tinc = 1'b1;
            if (!lfsr_rdy)
               state_d = WAIT;
            else if (tcnt >= TLIM) begin
               cap_timeout = 1'b1;
               state_d     = REPORT;
            end
         end
         WAIT: begin
            tinc = 1'b1;
            if (lfsr_rdy) begin
               capture = 1'b1;
               state_d = REPORT;
            end else if (tcnt >= TLIM) begin
               cap_timeout = 1'b1;
               state_d     = REPORT;
            end
         end
         REPORT: if (res_ready) begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seed_q      <= '0;
         exp_q       <= '0;
         tcnt        <= '0;
         res_sig     <= '0;
         res_pass    <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         if (accept) begin
            seed_q <= seed;
            exp_q  <= expected;
         end
         if (tclr)
            tcnt <= '0;
         else if (tinc)
            tcnt <= tcnt + 1'b1;
         if (capture) begin
            res_sig     <= lfsr_q;
            res_pass    <= (lfsr_q == exp_q);
            res_timeout <= 1'b0;
         end else if (cap_timeout) begin
            res_sig     <= '0;
            res_pass    <= 1'b0;
            res_timeout <= 1'b1;
         end
      end
   end

   assign lfsr_we   = (state_q == LOAD);
   assign lfsr_data = {{(DATA_W - NBITS){1'b0}}, seed_q};
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == REPORT);

   sat_counter #(.W(CNTW)) u_pass (
      .clk (clk),
      .rst (rst),
      .inc (done && res_pass),
      .cnt (pass_cnt)
   );

   sat_counter #(.W(CNTW)) u_fail (
      .clk (clk),
      .rst (rst),
      .inc (done && !res_pass),
      .cnt (fail_cnt)
   );

endmodule

// File: tb/tb_lfsr_sig_check.sv
// Bench for lfsr_sig_check: directed table, random checks against a
// transaction-level model, counter saturation and mid-check reset.
module tb_lfsr_sig_check;

   localparam int T = 32;

   logic          clk = 1'b0;
   logic          rst, start, lfsr_we, lfsr_rdy, busy, res_valid, res_ready;
   logic          res_pass, res_timeout;
   logic [15:0]   seed, expected, lfsr_q, res_sig;
   logic [127:0]  lfsr_data;
   logic [7:0]    pass_cnt, fail_cnt;

   int nvec = 0;
   int nerr = 0;
   int pcnt = 0;
   int fcnt = 0;

   lfsr_sig_check #(.NBITS(16), .DATA_W(128), .TIMEOUT(T), .CNTW(8)) dut (
      .clk (clk), .rst (rst), .start (start), .seed (seed), .expected (expected),
      .lfsr_we (lfsr_we), .lfsr_data (lfsr_data), .lfsr_q (lfsr_q), .lfsr_rdy (lfsr_rdy),
      .busy (busy), .res_valid (res_valid), .res_ready (res_ready), .res_pass (res_pass),
      .res_timeout (res_timeout), .res_sig (res_sig), .pass_cnt (pass_cnt), .fail_cnt (fail_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sd, ex, q;
      int          r1, z, dly;
      logic        pass, tmo;
      logic [15:0] sig;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      nvec++;
      if (act !== want) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Ready is 1 for r1 ARM/WAIT cycles, 0 for z cycles, then 1 again.
   function automatic logic rdy_at(input int i, input int r1, input int z);
      return (i < r1) ? 1'b1 : (i < r1 + z) ? 1'b0 : 1'b1;
   endfunction

   // Outcome from the rules: the first 0 at cycle a arms, the next 1 at cycle c
   // captures; the deadline is cycle T-1, extended by one only when arming lands on it.
   task automatic model(input int r1, input int z, output bit normal, output int rep);
      int a, c, lim;
      a = r1;
      c = r1 + z;
      lim = (a + 1 > T - 1) ? a + 1 : T - 1;
      normal = (a <= T - 1) && (c <= lim);
      rep = normal ? c + 1 : ((a == T - 1) ? T + 1 : T);
   endtask

   task automatic run_check(input vec_t v);
      bit normal;
      int rep, k;
      model(v.r1, v.z, normal, rep);
      seed      = v.sd;
      expected  = v.ex;
      lfsr_q    = v.q;
      start     = 1'b1;
      res_ready = (v.dly == 0);
      lfsr_rdy  = 1'b1;
      step();
      chk("load_we", lfsr_we, 1'b1);
      chk("load_data", lfsr_data, {112'd0, v.sd});
      start    = 1'b0;
      seed     = ~v.sd;
      expected = ~v.ex;
      lfsr_rdy = (v.r1 > 0);
      step();
      k = 0;
      while (k < 100 && !res_valid) begin
         if (lfsr_we !== 1'b0) chk("we_once", lfsr_we, 1'b0);
         lfsr_rdy = rdy_at(k, v.r1, v.z);
         step();
         k++;
      end
      chk("latency", k, rep);
      chk("valid", res_valid, 1'b1);
      chk("pass", res_pass, v.pass);
      chk("timeout", res_timeout, v.tmo);
      chk("sig", res_sig, v.sig);
      for (int d = 0; d < v.dly; d++) begin
         start    = 1'b1;
         seed     = 16'h7777;
         lfsr_rdy = ~lfsr_rdy;
         step();
         chk("hold_valid", res_valid, 1'b1);
         chk("hold_sig", res_sig, v.sig);
         chk("hold_pass", res_pass, v.pass);
         chk("hold_busy", busy, 1'b1);
      end
      res_ready = 1'b1;
      step();
      start     = 1'b0;
      res_ready = 1'b0;
      if (v.pass) pcnt = (pcnt < 255) ? pcnt + 1 : 255;
      else        fcnt = (fcnt < 255) ? fcnt + 1 : 255;
      chk("idle_busy", busy, 1'b0);
      chk("idle_valid", res_valid, 1'b0);
      chk("pass_cnt", pass_cnt, pcnt[7:0]);
      chk("fail_cnt", fail_cnt, fcnt[7:0]);
   endtask

   vec_t tbl[10];

   initial begin
      vec_t v;
      bit   nrm;
      int   rep;

      tbl[0] = '{16'h0001, 16'hBEEF, 16'hBEEF, 0, 3, 0, 1'b1, 1'b0, 16'hBEEF};
      tbl[1] = '{16'h0002, 16'h1234, 16'h4321, 0, 1, 0, 1'b0, 1'b0, 16'h4321};
      tbl[2] = '{16'h0003, 16'h5555, 16'hAAAA, 2, 1, 0, 1'b0, 1'b0, 16'hAAAA};
      tbl[3] = '{16'h0004, 16'h0000, 16'h0000, 0, 100, 0, 1'b0, 1'b1, 16'h0000};
      tbl[4] = '{16'h0005, 16'hCAFE, 16'hCAFE, 0, 2, 10, 1'b1, 1'b0, 16'hCAFE};
      tbl[5] = '{16'h0006, 16'h1111, 16'h1111, 31, 1, 0, 1'b1, 1'b0, 16'h1111};
      tbl[6] = '{16'h0007, 16'h2222, 16'h2222, 31, 2, 1, 1'b0, 1'b1, 16'h0000};
      tbl[7] = '{16'h0008, 16'h3333, 16'h3333, 32, 1, 0, 1'b0, 1'b1, 16'h0000};
      tbl[8] = '{16'h0009, 16'h4444, 16'h4444, 0, 31, 2, 1'b1, 1'b0, 16'h4444};
      tbl[9] = '{16'h000A, 16'h5555, 16'h5555, 0, 32, 0, 1'b0, 1'b1, 16'h0000};

      rst = 1'b1; start = 1'b0; seed = '0; expected = '0;
      lfsr_q = '0; lfsr_rdy = 1'b0; res_ready = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_we", lfsr_we, 1'b0);
      chk("rst_data", lfsr_data, 128'd0);
      chk("rst_sig", res_sig, 16'd0);
      chk("rst_cnts", {pass_cnt, fail_cnt}, 16'd0);
      rst = 1'b0;
      step();

      foreach (tbl[i]) run_check(tbl[i]);

      for (int n = 0; n < 30; n++) begin
         v.sd  = 16'($urandom);
         v.ex  = 16'($urandom);
         v.q   = $urandom_range(0, 1) ? v.ex : 16'($urandom);
         v.r1  = $urandom_range(0, 3);
         v.z   = $urandom_range(1, 36);
         v.dly = $urandom_range(0, 3);
         model(v.r1, v.z, nrm, rep);
         v.tmo  = !nrm;
         v.pass = nrm && (v.q == v.ex);
         v.sig  = nrm ? v.q : 16'h0;
         run_check(v);
      end

      for (int n = 0; n < 260; n++)
         run_check('{16'h00F0, 16'h0F0F, 16'h0F0F, 0, 1, 0, 1'b1, 1'b0, 16'h0F0F});
      chk("pass_sat", pass_cnt, 8'd255);

      // Abort partway through WAIT with a one-cycle reset.
      seed = 16'h00AB; expected = 16'h1357; start = 1'b1; lfsr_rdy = 1'b0;
      step();
      start = 1'b0;
      for (int n = 0; n < 6; n++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      pcnt = 0;
      fcnt = 0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_valid", res_valid, 1'b0);
      chk("abort_we", lfsr_we, 1'b0);
      chk("abort_cnts", {pass_cnt, fail_cnt}, 16'd0);
      lfsr_rdy = 1'b1;
      step();
      chk("abort_stay", res_valid, 1'b0);
      run_check('{16'h0123, 16'h9999, 16'h9999, 1, 2, 0, 1'b1, 1'b0, 16'h9999});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/lfsr_sig_check.md
Name: lfsr_sig_check

Overview:
Controller and consumer stage around the topcrc LFSR.
- On a start request it loads a seed into the LFSR (we/data) and waits for the LFSR ready flag.
- It then captures the LFSR output as the signature and compares it against an expected value.
- It reports pass/fail/timeout through a valid/ready result handshake and keeps saturating pass/fail counters for the top level.

Parameters:
NBITS, 16, LFSR width; also the width of seed, expected and signature.
DATA_W, 128, width of the LFSR load bus; the seed is zero-extended to this width.
TIMEOUT, 32, maximum cycles spent in ARM+WAIT before a check is declared timed out (>=2).
CNTW, 8, width of the pass/fail counters.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  check request, sampled only in IDLE.
seed  in  NBITS  seed value, captured when start is accepted.
expected  in  NBITS  reference signature, captured when start is accepted.
lfsr_we  out  1  one-cycle load strobe to the LFSR.
lfsr_data  out  DATA_W  load data to the LFSR: {zeros, captured seed}.
lfsr_q  in  NBITS  LFSR output.
lfsr_rdy  in  1  LFSR ready level.
busy  out  1  high in every state except IDLE.
res_valid  out  1  result valid.
res_ready  in  1  result accepted by the consumer.
res_pass  out  1  signature matched expected.
res_timeout  out  1  check aborted by timeout.
res_sig  out  NBITS  captured signature (0 on timeout).
pass_cnt  out  CNTW  saturating count of passes.
fail_cnt  out  CNTW  saturating count of fails and timeouts.

Behaviour:
Reset (rst=1 at a clock edge):
- State goes to IDLE.
- All outputs go to 0, including lfsr_data, res_sig and both counters.
- A reset mid-check aborts immediately: no result is produced and lfsr_we is 0 from the next cycle.

Registered FSM, states IDLE, LOAD, ARM, WAIT, REPORT:
- IDLE: if start=1 at edge t, capture seed and expected, go to LOAD.
- LOAD: lfsr_we=1 and lfsr_data valid for exactly this one cycle, during cycle t+1. Clear the timeout counter and go to ARM.
- ARM: wait until lfsr_rdy=0 is sampled, then go to WAIT. This rejects a stale ready level left over from a previous run.
- WAIT: on the first cycle lfsr_rdy=1 is sampled, capture lfsr_q into res_sig, set res_pass=(lfsr_q==expected), set res_timeout=0, and go to REPORT.
- Timeout: the timeout counter increments every cycle in ARM and WAIT. When it reaches TIMEOUT-1 without the exit condition, go to REPORT with res_timeout=1, res_pass=0, res_sig=0. If the exit condition and the timeout occur in the same cycle, the normal capture wins.
- REPORT: res_valid=1 and the result fields are held stable until res_valid&&res_ready. Then clear res_valid and go to IDLE.

Handshake and counters:
- res_valid is registered, so a res_ready that is already high causes the handshake on the first REPORT cycle, never earlier.
- pass_cnt or fail_cnt increments by 1 on the handshake cycle and saturates at 2^CNTW-1 (no wrap).

Other rules:
- start is ignored outside IDLE, including on the handshake cycle.
- A new check needs start in IDLE, so the minimum spacing between lfsr_we pulses is 5 cycles.
- seed and expected changing after acceptance have no effect.

Decomposition:
Package lfsr_chk_pkg holds:
- the state enum (IDLE, LOAD, ARM, WAIT, REPORT);
- default constants NBITS_DEF=16, DATA_W_DEF=128, TIMEOUT_DEF=32.

One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output cnt), is instantiated twice, for pass_cnt and fail_cnt. The timeout counter stays inline.

Test Plan:
1. Pass: seed=16'h0001, expected=16'hBEEF, start pulse. Bench drives lfsr_rdy 0 for 3 cycles then 1 with lfsr_q=16'hBEEF, res_ready=1. Required:
   - lfsr_we high exactly one cycle, with lfsr_data=128'h1;
   - res_valid, res_pass=1, res_sig=16'hBEEF;
   - pass_cnt=1, fail_cnt=0.
2. Mismatch: expected=16'h1234, lfsr_q=16'h4321 -> res_pass=0, res_timeout=0, res_sig=16'h4321, fail_cnt increments by 1.
3. Stale ready: lfsr_rdy held 1 through LOAD and 2 more cycles, then 0 for 1 cycle, then 1 with lfsr_q=16'hAAAA -> capture happens only after the 0 is observed; res_sig=16'hAAAA.
4. Timeout: lfsr_rdy stuck 0 with TIMEOUT=32 -> REPORT after 32 cycles in ARM/WAIT with res_timeout=1, res_sig=0, fail_cnt+1.
5. Backpressure and saturation: hold res_ready=0 for 10 cycles -> result stable and start ignored throughout. Run 260 passes with CNTW=8 -> pass_cnt=255.
6. Reset mid-WAIT: rst=1 for one cycle -> next cycle busy=0, res_valid=0, lfsr_we=0, counters 0. A following start works normally.
